// File: rtl/seq_det_param.sv
// Serial pattern detector: flags each PAT_LEN-bit match of a reloadable pattern, counts matches.
// Latency: seq_out and seq_num update one cycle after the edge that accepts the completing bit.
// Backpressure: none; always accepts, in_valid=0 cycles simply hold history.
module seq_det_param #(
    parameter int                   PAT_LEN = 5,
    parameter logic [PAT_LEN-1:0]   PATTERN = 5'b11011,
    parameter int                   CNT_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               seq_in,
    input  logic               in_valid,
    input  logic               overlap_en,
    input  logic               pat_load,
    input  logic [PAT_LEN-1:0] pat_in,
    input  logic               cnt_clr,
    output logic               seq_out,
    output logic [CNT_W-1:0]   seq_num,
    output logic               cnt_sat
);
    localparam int FW = $clog2(PAT_LEN + 1);
    localparam logic [FW-1:0]    FILL_FULL = FW'(PAT_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    logic [PAT_LEN-1:0] hist;
    logic [PAT_LEN-1:0] hist_nx;
    logic [PAT_LEN-1:0] pat_r;
    logic [FW-1:0]      fill;
    logic [FW-1:0]      fill_nx;
    logic [CNT_W-1:0]   seq_num_inc;
    logic               match;
    logic               accept;

    always_comb begin
        accept      = in_valid && !pat_load;
        hist_nx     = {hist[PAT_LEN-2:0], seq_in};
        fill_nx     = (fill == FILL_FULL) ? fill : fill + FW'(1);
        match       = accept && (fill_nx == FILL_FULL) && (hist_nx == pat_r);
        seq_num_inc = seq_num + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hist    <= '0;
            fill    <= '0;
            pat_r   <= PATTERN;
            seq_out <= 1'b0;
            seq_num <= '0;
            cnt_sat <= 1'b0;
        end else begin
            seq_out <= match;

            // A load discards any bit presented alongside it and restarts the fill.
            if (pat_load) begin
                pat_r <= pat_in;
                fill  <= '0;
            end else if (in_valid) begin
                hist <= hist_nx;
                if (match && !overlap_en)
                    fill <= '0;
                else
                    fill <= fill_nx;
            end

            // Clear wins over a same-cycle match; the pulse itself is unaffected.
            if (cnt_clr) begin
                seq_num <= '0;
                cnt_sat <= 1'b0;
            end else if (match && seq_num != CNT_MAX) begin
                seq_num <= seq_num_inc;
                if (seq_num_inc == CNT_MAX)
                    cnt_sat <= 1'b1;
            end
        end
    end
endmodule

// File: doc/seq_det_param.md
# seq_det_param

Parametrised serial pattern detector, the generalised successor to the fixed 11011 detector. It accepts one bit per valid cycle and flags every completed occurrence of a PAT_LEN-bit pattern. The pattern defaults to a parameter and can be reloaded at run time. Overlapping or non-overlapping detection is selectable live, and a saturating occurrence counter with a sticky saturation flag is provided. It sits directly behind the serial test-stimulus source and feeds the match pulse and count to the checker logic.

## Interface
- PAT_LEN, 5, pattern length in bits; legal range 2..32
- PATTERN, 5'b11011, reset and default pattern; MSB is the first bit received
- CNT_W, 4, width of the occurrence counter
- clk  input  1  rising-edge clock; the only clock
- reset  input  1  synchronous, active-high reset
- seq_in  input  1  serial data bit, sampled when in_valid=1
- in_valid  input  1  qualifies seq_in; a cycle with in_valid=0 leaves history untouched
- overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping; sampled every accepted bit
- pat_load  input  1  one-cycle strobe that loads pat_in into the pattern register
- pat_in  input  PAT_LEN  new pattern, MSB first-received
- cnt_clr  input  1  one-cycle strobe that clears seq_num and cnt_sat
- seq_out  output  1  one-cycle match pulse (registered)
- seq_num  output  CNT_W  saturating count of matches
- cnt_sat  output  1  sticky flag; set when seq_num reaches all-ones

## Operation
- State:
  - hist[PAT_LEN-1:0], shift history
  - fill[clog2(PAT_LEN+1)-1:0], number of valid history bits, saturates at PAT_LEN
  - pat_r[PAT_LEN-1:0], active pattern
  - seq_num, cnt_sat, seq_out
- Accepted bit (in_valid=1, pat_load=0):
  - hist_nx = {hist[PAT_LEN-2:0], seq_in}
  - fill_nx = min(fill+1, PAT_LEN)
  - match = (fill_nx == PAT_LEN) && (hist_nx == pat_r)
- On match:
  - seq_out <= 1
  - seq_num increments unless it is already all-ones
  - cnt_sat <= 1 when seq_num_next == all-ones
  - If overlap_en=0, fill <= 0 so the next match needs PAT_LEN fresh bits. hist still loads hist_nx, but it is ignored until refilled.
  - If overlap_en=1, fill stays at PAT_LEN.
- No match, or in_valid=0: seq_out <= 0. in_valid=0 leaves hist and fill unchanged; gaps in in_valid do not break a pattern.
- pat_load=1:
  - pat_r <= pat_in, fill <= 0, seq_out <= 0
  - Any bit presented in the same cycle is discarded, since load has priority over in_valid.
  - seq_num and cnt_sat are unaffected.
- cnt_clr=1: seq_num <= 0, cnt_sat <= 0. If a match occurs in the same cycle:
  - clear has priority, so seq_num = 0
  - seq_out still pulses
  - hist and fill update normally
- Saturation: once seq_num = 2^CNT_W-1, further matches still pulse seq_out. seq_num holds and cnt_sat stays 1 until cnt_clr or reset.
- Priority, highest first: reset > pat_load > in_valid; cnt_clr acts on the counter path only.

## Timing
- Reset state, present on the first edge with reset=1 and held while it is asserted:
  - seq_out=0, seq_num=0, cnt_sat=0
  - hist=0, fill=0, pat_r=PATTERN
- Reset during a partial pattern discards the history. Detection restarts from an empty fill.
- Latency: the final bit is accepted at edge N. seq_out is high in the cycle after edge N, for exactly one cycle. seq_num shows the incremented value in the same cycle.
- Back-to-back matches:
  - Overlap mode: seq_out may be high on consecutive accepted-bit cycles when the pattern self-overlaps (e.g. all-ones).
  - Non-overlap mode: successive matches are at least PAT_LEN accepted bits apart.
- A pat_load at edge N takes effect for bits accepted at edge N+1 and later.
- overlap_en is sampled at the edge that accepts the matching bit.
- No combinational input-to-output paths; all outputs are registered.

## Test plan
- Reset, defaults, overlap_en=1: feed 1,1,0,1,1 with in_valid=1 -> seq_out pulses one cycle after the 5th bit, seq_num=1. Repeat with in_valid=0 gap cycles between bits -> same result, with the pulse delayed only by the gaps.
- Stream 1,1,0,1,1,0,1,1:
  - overlap_en=1 -> pulses after bits 5 and 8, seq_num=2
  - overlap_en=0 -> a single pulse after bit 5, seq_num=1
- pat_load with pat_in=5'b10110, in the same cycle as in_valid=1 -> that bit is discarded. Then feed 1,1,0,1,1 -> no pulse. Then feed 1,0,1,1,0 -> one pulse.
- CNT_W=4, 16 consecutive non-overlap matches of 11011:
  - seq_num reaches 15 on the 15th match and holds at 15 on the 16th, while seq_out still pulses
  - cnt_sat=1 from the 15th match onward
  - cnt_clr then gives seq_num=0, cnt_sat=0
- cnt_clr asserted in the same cycle as the completing bit -> seq_out=1, seq_num=0.
- reset asserted after 1,1,0,1, then released, then feed 1 -> no pulse, fill=1, all outputs at reset values. Then feed 1,0,1,1 -> pulse.
